// File: rtl/duty_cycle_meter_pkg.sv
// Shared types and constants for the duty-cycle meter: FSM states, percent scaling
// and the divider width helper.
package duty_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int unsigned PCT_W     = 7;
  localparam int unsigned PCT_SCALE = 100;

  function automatic int unsigned div_width(input int unsigned cnt_w);
    return cnt_w + PCT_W;
  endfunction

endpackage

// File: rtl/duty_cycle_meter_if.sv
// Measurement bus of the duty-cycle meter: control/sample inputs and result outputs.
interface duty_cycle_meter_if #(
  parameter int unsigned CNT_W = 16
);

  logic                            enable;
  logic                            sig_in;
  logic [CNT_W-1:0]                period_cnt;
  logic [CNT_W-1:0]                high_cnt;
  logic [duty_meter_pkg::PCT_W-1:0] duty_pct;
  logic                            meas_valid;
  logic                            stalled;
  logic                            overrun;

  modport master (
    output enable, sig_in,
    input  period_cnt, high_cnt, duty_pct, meas_valid, stalled, overrun
  );

  modport slave (
    input  enable, sig_in,
    output period_cnt, high_cnt, duty_pct, meas_valid, stalled, overrun
  );

endinterface

// File: rtl/duty_cycle_meter_div.sv
// Sequential restoring unsigned divider, one quotient bit per cycle; a zero divisor
// yields a zero quotient.
module duty_meter_div
  import duty_meter_pkg::*;
#(
  parameter int unsigned DVD_W = 23,
  parameter int unsigned DVS_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_abort,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);

  localparam int unsigned          ITER_W    = $clog2(DVD_W) + 1;
  localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(DVD_W - 1);

  logic [DVD_W-1:0]  r_quo;
  logic [DVS_W-1:0]  r_rem;
  logic [DVS_W-1:0]  r_dvs;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_done;
  logic              r_dz;

  logic [DVS_W:0]    w_trial;
  logic              w_ge;
  logic [DVS_W-1:0]  w_diff;

  // Remainder stays below the divisor, so the restored value always fits DVS_W bits.
  assign w_trial = {r_rem, r_quo[DVD_W-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = DVS_W'(w_trial - {1'b0, r_dvs});

  always_ff @(posedge clk) begin
    if (!rst_n || i_abort) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_dvs  <= i_divisor;
        r_iter <= '0;
        r_busy <= 1'b1;
        r_dz   <= (i_divisor == '0);
      end else if (r_busy) begin
        r_quo  <= {r_quo[DVD_W-2:0], w_ge};
        r_rem  <= w_ge ? w_diff : w_trial[DVS_W-1:0];
        r_iter <= r_iter + ITER_W'(1);
        if (r_iter == LAST_ITER) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_dz ? '0 : r_quo;

endmodule

// File: rtl/duty_cycle_meter.sv
// Duty-cycle meter: syncs sig_in, measures period/high time, divides for percent.
// Define DUTY_METER_AVG_EN to report the average of every four periods instead.
module duty_cycle_meter
  import duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  duty_cycle_meter_if.slave  bus
);

  localparam int unsigned       DW       = div_width(CNT_W);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;
  logic [CNT_W-1:0] r_per_cap;
  logic [CNT_W-1:0] r_hc_cap;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [PCT_W-1:0] r_duty;
  logic             r_valid;
  logic             r_stalled;
  logic             r_overrun;

  logic             w_rise, w_fall, w_edge;
  logic             w_active, w_timeout, w_period_done;
  logic             w_launch, w_start, w_abort;
  logic [CNT_W-1:0] w_launch_per, w_launch_hc;
  logic [DW-1:0]    w_dividend, w_quo;
  logic             w_div_busy, w_div_done;
  logic [PCT_W-1:0] w_duty;

  assign w_rise        = r_s2 & ~r_s3;
  assign w_fall        = ~r_s2 & r_s3;
  assign w_edge        = w_rise | w_fall;
  assign w_active      = bus.enable && (r_state != IDLE);
  // Once stalled has been reported the timeout stays quiet until the next edge.
  assign w_timeout     = w_active && !r_stalled && !w_edge && (r_tmo == TMO_LAST);
  assign w_period_done = bus.enable && (r_state == MEASURE) && w_rise;

`ifdef DUTY_METER_AVG_EN
  logic [CNT_W+1:0] r_acc_per, r_acc_hc;
  logic [CNT_W+1:0] w_sum_per, w_sum_hc;
  logic [1:0]       r_nper;

  assign w_sum_per    = r_acc_per + (CNT_W+2)'(r_cnt);
  assign w_sum_hc     = r_acc_hc + (CNT_W+2)'(r_hi_cap);
  assign w_launch     = w_period_done && (r_nper == 2'd3);
  assign w_launch_per = CNT_W'(w_sum_per >> 2);
  assign w_launch_hc  = CNT_W'(w_sum_hc >> 2);

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.enable || (r_state != MEASURE) || w_timeout) begin
      r_acc_per <= '0;
      r_acc_hc  <= '0;
      r_nper    <= '0;
    end else if (w_rise) begin
      if (r_nper == 2'd3) begin
        r_acc_per <= '0;
        r_acc_hc  <= '0;
        r_nper    <= '0;
      end else begin
        r_acc_per <= w_sum_per;
        r_acc_hc  <= w_sum_hc;
        r_nper    <= r_nper + 2'd1;
      end
    end
  end
`else
  assign w_launch     = w_period_done;
  assign w_launch_per = r_cnt;
  assign w_launch_hc  = r_hi_cap;
`endif

  assign w_start    = w_launch && !w_div_busy;
  assign w_abort    = !bus.enable || w_timeout;
  assign w_dividend = DW'(w_launch_hc) * DW'(PCT_SCALE);
  assign w_duty     = (w_quo > DW'(PCT_SCALE)) ? PCT_W'(PCT_SCALE) : w_quo[PCT_W-1:0];

  duty_meter_div #(
    .DVD_W (DW),
    .DVS_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_abort    (w_abort),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_launch_per),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_cnt     <= '0;
      r_hi_cap  <= '0;
      r_per_cap <= '0;
      r_hc_cap  <= '0;
      r_tmo     <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_stalled <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_s1    <= bus.sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;

      if (w_start) begin
        r_per_cap <= w_launch_per;
        r_hc_cap  <= w_launch_hc;
      end

      if (w_div_done && bus.enable && !w_timeout) begin
        r_period <= r_per_cap;
        r_high   <= r_hc_cap;
        r_duty   <= w_duty;
        r_valid  <= 1'b1;
      end

      if (!bus.enable) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_hi_cap  <= '0;
        r_tmo     <= '0;
        r_stalled <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt     <= '0;
            r_hi_cap  <= '0;
            r_stalled <= 1'b0;
            r_state   <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_state   <= MEASURE;
              r_cnt     <= CNT_W'(1);
              r_stalled <= 1'b0;
            end
          end
          MEASURE: begin
            if (w_rise)             r_cnt <= CNT_W'(1);
            else if (r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
            if (w_fall)             r_hi_cap <= r_cnt;
            if (w_launch && w_div_busy) r_overrun <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase

        if (r_state == IDLE || w_edge || w_timeout || r_stalled) r_tmo <= '0;
        else                                                    r_tmo <= r_tmo + CNT_W'(1);

        if (w_timeout) begin
          r_state   <= ARM;
          r_cnt     <= '0;
          r_stalled <= 1'b1;
          r_period  <= '0;
          r_high    <= '0;
          r_duty    <= r_s2 ? PCT_W'(PCT_SCALE) : '0;
          r_valid   <= 1'b1;
        end
      end
    end
  end

  assign bus.period_cnt = r_period;
  assign bus.high_cnt   = r_high;
  assign bus.duty_pct   = r_duty;
  assign bus.meas_valid = r_valid;
  assign bus.stalled    = r_stalled;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Directed bench for duty_cycle_meter with hand-computed expectations (TIMEOUT=100).
module tb_duty_cycle_meter;

  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_tot    = 0;
  int unsigned n_bad    = 0;
  int unsigned nvalid   = 0;
  int unsigned cyc      = 0;
  int unsigned rise_cyc = 0;
  int unsigned lat      = 0;
  int unsigned nv0;

  duty_cycle_meter_if #(.CNT_W(CNT_W)) bus ();

  duty_cycle_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.meas_valid === 1'b1) begin
      nvalid++;
      lat = cyc - rise_cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},  bus.period_cnt, 0);
    chk({tag, "_high"},    bus.high_cnt,   0);
    chk({tag, "_duty"},    bus.duty_pct,   0);
    chk({tag, "_valid"},   bus.meas_valid, 0);
    chk({tag, "_stalled"}, bus.stalled,    0);
    chk({tag, "_overrun"}, bus.overrun,    0);
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sig_in = 1'b1;
      rise_cyc   = cyc;
      wait_cyc(hi);
      bus.sig_in = 1'b0;
      wait_cyc(lo);
    end
  endtask

  task automatic chk_result(input string tag, input int per, input int hi, input int pct);
    chk({tag, "_period"}, bus.period_cnt, per);
    chk({tag, "_high"},   bus.high_cnt,   hi);
    chk({tag, "_duty"},   bus.duty_pct,   pct);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    wait_cyc(3);
    chk_zero("reset");
    rst_n = 1'b1;

`ifdef DUTY_METER_AVG_EN
    bus.enable = 1'b1;
    run_wave(20, 20, 1);
    run_wave(20, 20, 1);
    run_wave(22, 22, 1);
    run_wave(18, 18, 1);
    chk("avg_no_early_valid", nvalid, 0);
    run_wave(20, 20, 1);
    chk("avg_valid_count", nvalid, 1);
    chk_result("avg", 40, 20, 50);
    chk("avg_overrun", bus.overrun, 0);
`else
    bus.enable = 1'b1;
    nv0 = nvalid;
    run_wave(10, 30, 4);
    chk("d25_valid_count", nvalid - nv0, 3);
    chk_result("d25", 40, 10, 25);
    chk("d25_latency", lat, 27);

    run_wave(20, 20, 3);
    chk_result("d50", 40, 20, 50);

    run_wave(30, 10, 3);
    chk_result("d75", 40, 30, 75);
    chk("d75_overrun", bus.overrun, 0);

    bus.sig_in = 1'b1;
    wait_cyc(60);
    nv0 = nvalid;
    wait_cyc(250);
    chk("stall_pulses", nvalid - nv0, 1);
    chk("stall_flag", bus.stalled, 1);
    chk_result("stall", 0, 0, 100);
    bus.sig_in = 1'b0;
    wait_cyc(10);
    chk("stall_hold_on_fall", bus.stalled, 1);
    bus.sig_in = 1'b1;
    wait_cyc(5);
    chk("stall_clear_on_rise", bus.stalled, 0);

    run_wave(4, 4, 20);
    wait_cyc(30);
    chk("short_overrun", bus.overrun, 1);
    chk_result("short", 8, 4, 50);

    run_wave(20, 20, 3);
    chk("overrun_sticky", bus.overrun, 1);

    nv0 = nvalid;
    bus.sig_in = 1'b1;
    wait_cyc(20);
    bus.sig_in = 1'b0;
    wait_cyc(2);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    chk_zero("midrst");
    wait_cyc(17);
    run_wave(20, 20, 1);
    chk("midrst_no_valid", nvalid - nv0, 0);
    run_wave(20, 20, 1);
    chk("midrst_first_valid", nvalid - nv0, 1);
    chk_result("midrst", 40, 20, 50);

    nv0 = nvalid;
    bus.enable = 1'b0;
    wait_cyc(10);
    chk("en_off_no_valid", nvalid - nv0, 0);
    chk_result("en_off_hold", 40, 20, 50);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
